// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx_if
// Purpose  : 3-wire serial bus plus parallel frame outputs of serial_frame_rx.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_frame_rx_if #(
   parameter int FRAME_BITS = 64
);
   logic                  s_clk;
   logic                  s_sout;
   logic                  s_clrn;
   logic [FRAME_BITS-1:0] data_out;
   logic                  frame_valid;
   logic                  busy;
   logic [6:0]            bit_cnt;
   logic                  frame_err;
   logic [7:0]            err_cnt;

   // The serial source drives the bus and observes the receiver outputs.
   modport master (
      output s_clk, s_sout, s_clrn,
      input  data_out, frame_valid, busy, bit_cnt, frame_err, err_cnt
   );

   modport slave (
      input  s_clk, s_sout, s_clrn,
      output data_out, frame_valid, busy, bit_cnt, frame_err, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Oversampling deserializer for the 3-wire shift bus (s_clk, s_sout,
//            s_clrn); presents each fixed-length frame with a 1-cycle strobe.
// Option   : SERIAL_FRAME_RX_TIMEOUT_EN enables the idle-timeout abort logic.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
   parameter int FRAME_BITS     = 64,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  wire logic         clk,
   input  wire logic         rst,
   serial_frame_rx_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic [6:0] c_last_bit = 7'(FRAME_BITS - 1);

   generate
      if (FRAME_BITS < 2 || FRAME_BITS > 64) begin : g_bad_frame_bits
         $error("serial_frame_rx: FRAME_BITS must be within 2..64");
      end
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("serial_frame_rx: TIMEOUT_CYCLES must be at least 2");
      end
   endgenerate

   logic [1:0]            r_clk_sync;
   logic [1:0]            r_sout_sync;
   logic [1:0]            r_clrn_sync;
   logic                  r_clk_hist;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [FRAME_BITS-2:0] r_shreg;
   logic [FRAME_BITS-2:0] w_shreg_nxt;
   logic [FRAME_BITS-1:0] w_shifted;
   logic [6:0]            r_bit_cnt;
   logic [6:0]            w_bit_cnt_nxt;
   logic                  w_commit;
   logic [FRAME_BITS-1:0] r_data;
   logic                  r_frame_valid;

   logic                  w_edge;
   logic                  w_clr;
   logic                  w_bit;
   logic                  w_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_sync  <= 2'b00;
         r_sout_sync <= 2'b00;
         r_clrn_sync <= 2'b00;
         r_clk_hist  <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0],  bus.s_clk};
         r_sout_sync <= {r_sout_sync[0], bus.s_sout};
         r_clrn_sync <= {r_clrn_sync[0], bus.s_clrn};
         r_clk_hist  <= r_clk_sync[1];
      end
   end

   assign w_edge = r_clk_sync[1] & ~r_clk_hist;
   assign w_clr  = ~r_clrn_sync[1];
   assign w_bit  = r_sout_sync[1];

   // The register holds only the first FRAME_BITS-1 bits; the final bit is
   // appended on the fly so the committed word includes it.
   assign w_shifted = {r_shreg, w_bit};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      w_commit      = 1'b0;
      if (w_clr) begin
         w_state_nxt   = ST_IDLE;
         w_shreg_nxt   = '0;
         w_bit_cnt_nxt = 7'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_edge) begin
                  w_shreg_nxt   = w_shifted[FRAME_BITS-2:0];
                  w_bit_cnt_nxt = 7'd1;
                  w_state_nxt   = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_edge) begin
                  if (r_bit_cnt == c_last_bit) begin
                     w_commit      = 1'b1;
                     w_shreg_nxt   = '0;
                     w_bit_cnt_nxt = 7'd0;
                     w_state_nxt   = ST_IDLE;
                  end else begin
                     w_shreg_nxt   = w_shifted[FRAME_BITS-2:0];
                     w_bit_cnt_nxt = r_bit_cnt + 7'd1;
                  end
               end else if (w_timeout) begin
                  w_shreg_nxt   = '0;
                  w_bit_cnt_nxt = 7'd0;
                  w_state_nxt   = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt   = ST_IDLE;
               w_shreg_nxt   = '0;
               w_bit_cnt_nxt = 7'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg       <= '0;
         r_bit_cnt     <= 7'd0;
         r_data        <= '0;
         r_frame_valid <= 1'b0;
      end else begin
         r_shreg       <= w_shreg_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_frame_valid <= w_commit;
         if (w_commit) begin
            r_data <= w_shifted;
         end
      end
   end

`ifdef SERIAL_FRAME_RX_TIMEOUT_EN
   localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_to_w-1:0] c_timeout = c_to_w'(TIMEOUT_CYCLES);

   logic [c_to_w-1:0] r_to_cnt;
   logic              r_frame_err;
   logic [7:0]        r_err_cnt;
   logic              w_abort;

   assign w_timeout = (r_state == ST_SHIFT) && (r_to_cnt == c_timeout);
   // An edge or a clear in the same cycle takes precedence over the abort.
   assign w_abort   = w_timeout && !w_edge && !w_clr;

   always_ff @(posedge clk) begin
      if (rst || (r_state != ST_SHIFT) || w_edge) begin
         r_to_cnt <= '0;
      end else if (!w_timeout) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_err_cnt   <= 8'd0;
      end else begin
         r_frame_err <= w_abort;
         if (w_abort && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign bus.frame_err = r_frame_err;
   assign bus.err_cnt   = r_err_cnt;
`else
   assign w_timeout     = 1'b0;
   assign bus.frame_err = 1'b0;
   assign bus.err_cnt   = 8'd0;
`endif

   assign bus.data_out    = r_data;
   assign bus.frame_valid = r_frame_valid;
   assign bus.busy        = (r_state == ST_SHIFT);
   assign bus.bit_cnt     = r_bit_cnt;

endmodule
`default_nettype wire
